// File: rtl/coarse_ctrl.sv
// -----------------------------------------------------------------------------
// coarse_ctrl
//
// Coarse-stage controller of the delay-line tuning loop. It sits at the far end
// of the fine shift register's carry interface: every one-cycle wrap pulse from
// the fine stage moves a saturating coarse code by one cell. The code is also
// driven out as a thermometer select for the coarse delay cells.
//
// After each accepted coarse step the fine stage is gated off (fine_en low) for
// SETTLE_CYC cycles so the coarse delay can settle before fine tracking resumes.
// A run of LOCK_CYC consecutive carry-free tracking cycles raises locked. A
// carry that would push the code past either end sets the sticky sat_err flag.
//
// Ports
//   clk            system clock, rising edge
//   rst            asynchronous, active-low reset
//   enable         loop enable; low forces the idle state
//   carry_in_incr  fine stage wrapped upward (one-cycle pulse)
//   carry_in_decr  fine stage wrapped downward (one-cycle pulse)
//   fine_en        registered enable to the fine stage
//   coarse_code    binary coarse setting, 0..COARSE_NUM
//   coarse_sel     registered thermometer, bit i = (i < coarse_code)
//   locked         registered lock indicator
//   sat_err        sticky saturation flag
// -----------------------------------------------------------------------------
module coarse_ctrl #(
   parameter int COARSE_NUM = 8,
   parameter int INIT_CODE  = 4,
   parameter int SETTLE_CYC = 4,
   parameter int LOCK_CYC   = 64,
   localparam int CW        = $clog2(COARSE_NUM + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic                  carry_in_incr,
   input  logic                  carry_in_decr,
   output logic                  fine_en,
   output logic [CW-1:0]         coarse_code,
   output logic [COARSE_NUM-1:0] coarse_sel,
   output logic                  locked,
   output logic                  sat_err
);

   // Counter widths: each must hold its largest value (LOCK_CYC for the quiet
   // counter, SETTLE_CYC-1 for the settle counter).
   localparam int QW = $clog2(LOCK_CYC + 1);
   localparam int SW = $clog2(SETTLE_CYC + 1);

   localparam logic [CW-1:0] MAX_CODE    = CW'(COARSE_NUM);
   localparam logic [CW-1:0] RST_CODE    = CW'(INIT_CODE);
   localparam logic [QW-1:0] LOCK_MAX    = QW'(LOCK_CYC);
   localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYC - 1);

   // Loop states
   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_TRACK  = 2'd1;
   localparam logic [1:0] S_SETTLE = 2'd2;

   // --------------------------------------------------------------------------
   // State registers and their next values
   // --------------------------------------------------------------------------
   logic [1:0]            state_reg,   state_next;
   logic [CW-1:0]         code_reg,    code_next;
   logic [COARSE_NUM-1:0] sel_reg,     sel_next;
   logic                  fine_en_reg, fine_en_next;
   logic                  locked_reg,  locked_next;
   logic                  sat_reg,     sat_next;
   logic [SW-1:0]         settle_reg,  settle_next;
   logic [QW-1:0]         quiet_reg,   quiet_next;

   // Carry decode. Both pulses at once is an illegal combination from the fine
   // stage; it is treated as "not quiet" but causes no step.
   logic carry_any;
   logic carry_both;
   logic at_top;
   logic at_bottom;

   assign carry_any  = carry_in_incr | carry_in_decr;
   assign carry_both = carry_in_incr & carry_in_decr;
   assign at_top     = (code_reg == MAX_CODE);
   assign at_bottom  = (code_reg == '0);

   // --------------------------------------------------------------------------
   // Next-state logic
   // --------------------------------------------------------------------------
   always_comb begin
      state_next   = state_reg;
      code_next    = code_reg;
      fine_en_next = fine_en_reg;
      locked_next  = locked_reg;
      sat_next     = sat_reg;
      settle_next  = settle_reg;
      quiet_next   = quiet_reg;

      if (!enable) begin
         // Disabling wins over everything, including a carry in this cycle.
         // The code and the sticky flag survive so the loop resumes where it
         // left off.
         state_next   = S_IDLE;
         fine_en_next = 1'b0;
         locked_next  = 1'b0;
         quiet_next   = '0;
         settle_next  = '0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               state_next   = S_TRACK;
               fine_en_next = 1'b1;
               locked_next  = 1'b0;
               quiet_next   = '0;
            end

            S_TRACK: begin
               if (carry_any) begin
                  // Any carry activity breaks the quiet run.
                  quiet_next  = '0;
                  locked_next = 1'b0;
                  if (!carry_both) begin
                     if (carry_in_incr) begin
                        if (at_top) begin
                           sat_next = 1'b1;
                        end else begin
                           code_next    = code_reg + CW'(1);
                           state_next   = S_SETTLE;
                           fine_en_next = 1'b0;
                           settle_next  = SETTLE_LOAD;
                        end
                     end else begin
                        if (at_bottom) begin
                           sat_next = 1'b1;
                        end else begin
                           code_next    = code_reg - CW'(1);
                           state_next   = S_SETTLE;
                           fine_en_next = 1'b0;
                           settle_next  = SETTLE_LOAD;
                        end
                     end
                  end
               end else begin
                  // Quiet counter saturates at LOCK_CYC so lock holds for as
                  // long as tracking stays carry-free.
                  if (quiet_reg != LOCK_MAX) begin
                     quiet_next = quiet_reg + QW'(1);
                  end
                  locked_next = (quiet_next == LOCK_MAX);
               end
            end

            S_SETTLE: begin
               // Carries are ignored here: the fine stage is gated off and any
               // pulse is a leftover of the step just taken.
               if (settle_reg == '0) begin
                  state_next   = S_TRACK;
                  fine_en_next = 1'b1;
               end else begin
                  settle_next = settle_reg - SW'(1);
               end
            end

            default: begin
               // Unused encoding: fall back to a safe idle.
               state_next   = S_IDLE;
               fine_en_next = 1'b0;
               locked_next  = 1'b0;
               quiet_next   = '0;
               settle_next  = '0;
            end
         endcase
      end
   end

   // --------------------------------------------------------------------------
   // Thermometer select, computed from the next code so coarse_sel changes on
   // the same edge as coarse_code.
   // --------------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < COARSE_NUM; gi++) begin : g_therm
         assign sel_next[gi] = (code_next > CW'(gi));
      end
   endgenerate

   // Reset value of the thermometer, derived the same way from INIT_CODE.
   logic [COARSE_NUM-1:0] sel_rst;

   generate
      for (genvar gi = 0; gi < COARSE_NUM; gi++) begin : g_therm_rst
         assign sel_rst[gi] = (RST_CODE > CW'(gi));
      end
   endgenerate

   // --------------------------------------------------------------------------
   // Registers
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg   <= S_IDLE;
         code_reg    <= RST_CODE;
         sel_reg     <= sel_rst;
         fine_en_reg <= 1'b0;
         locked_reg  <= 1'b0;
         sat_reg     <= 1'b0;
         settle_reg  <= '0;
         quiet_reg   <= '0;
      end else begin
         state_reg   <= state_next;
         code_reg    <= code_next;
         sel_reg     <= sel_next;
         fine_en_reg <= fine_en_next;
         locked_reg  <= locked_next;
         sat_reg     <= sat_next;
         settle_reg  <= settle_next;
         quiet_reg   <= quiet_next;
      end
   end

   assign fine_en     = fine_en_reg;
   assign coarse_code = code_reg;
   assign coarse_sel  = sel_reg;
   assign locked      = locked_reg;
   assign sat_err     = sat_reg;

endmodule

// File: tb/tb_coarse_ctrl.sv
// -----------------------------------------------------------------------------
// tb_coarse_ctrl
//
// Directed scenarios followed by randomized carry/enable/reset traffic. A
// behavioural model of the loop (integer code, running flag, cycles of fine
// gating left, quiet-cycle count) predicts every output; a compare process
// checks the DUT against it on every falling edge. Literal expectations in the
// directed part pin the model itself.
// -----------------------------------------------------------------------------
module tb_coarse_ctrl;

   localparam int N    = 8;
   localparam int INIT = 4;
   localparam int SC   = 4;
   localparam int LC   = 64;

   logic         clk    = 1'b0;
   logic         rst    = 1'b0;
   logic         enable = 1'b0;
   logic         inc    = 1'b0;
   logic         dec    = 1'b0;
   logic         fine_en;
   logic [3:0]   coarse_code;
   logic [N-1:0] coarse_sel;
   logic         locked;
   logic         sat_err;

   int checks = 0;
   int errors = 0;

   coarse_ctrl #(
      .COARSE_NUM (N),
      .INIT_CODE  (INIT),
      .SETTLE_CYC (SC),
      .LOCK_CYC   (LC)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .enable        (enable),
      .carry_in_incr (inc),
      .carry_in_decr (dec),
      .fine_en       (fine_en),
      .coarse_code   (coarse_code),
      .coarse_sel    (coarse_sel),
      .locked        (locked),
      .sat_err       (sat_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Behavioural model
   // ---------------------------------------------------------------------------
   int m_code  = INIT;
   bit m_sat   = 0;
   bit m_run   = 0;    // loop enabled and past its idle cycle
   int m_gate  = 0;    // cycles of fine gating still to come
   int m_quiet = 0;    // consecutive carry-free tracking cycles

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_code  = INIT;
         m_sat   = 0;
         m_run   = 0;
         m_gate  = 0;
         m_quiet = 0;
      end else if (!enable) begin
         m_run   = 0;
         m_gate  = 0;
         m_quiet = 0;
      end else if (!m_run) begin
         m_run = 1;
      end else if (m_gate > 0) begin
         m_gate--;
      end else if (inc && dec) begin
         m_quiet = 0;
      end else if (inc) begin
         m_quiet = 0;
         if (m_code < N) begin m_code++; m_gate = SC; end
         else m_sat = 1;
      end else if (dec) begin
         m_quiet = 0;
         if (m_code > 0) begin m_code--; m_gate = SC; end
         else m_sat = 1;
      end else if (m_quiet < LC) begin
         m_quiet++;
      end
   end

   always @(negedge clk) begin
      logic [N-1:0] exp_sel;
      bit exp_fine;
      for (int i = 0; i < N; i++) exp_sel[i] = (i < m_code);
      exp_fine = m_run && (m_gate == 0);
      chk("cmp_code",   32'(coarse_code), 32'(m_code));
      chk("cmp_sel",    32'(coarse_sel),  32'(exp_sel));
      chk("cmp_fine",   32'(fine_en),     32'(exp_fine));
      chk("cmp_locked", 32'(locked),      32'(exp_fine && (m_quiet >= LC)));
      chk("cmp_sat",    32'(sat_err),     32'(m_sat));
      $display("cyc t=%0t en=%0b inc=%0b dec=%0b code=%0d sel=%b fine=%0b lock=%0b sat=%0b",
               $time, enable, inc, dec, coarse_code, coarse_sel, fine_en, locked, sat_err);
   end

   // ---------------------------------------------------------------------------
   // Stimulus helpers: inputs change 2 time units after the rising edge.
   // ---------------------------------------------------------------------------
   task automatic cyc(input logic e, input logic i, input logic d);
      enable = e;
      inc    = i;
      dec    = d;
      @(posedge clk);
      #2;
   endtask

   task automatic restart();
      rst = 1'b0;
      cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      rst = 1'b1;
      cyc(1'b1, 1'b0, 1'b0);
      chk("restart_fine", 32'(fine_en), 32'd1);
   endtask

   task automatic wait_settle();
      int n = 0;
      while (fine_en !== 1'b1 && n < 20) begin
         cyc(1'b1, 1'b0, 1'b0);
         n++;
      end
      chk("settle_done", 32'(fine_en), 32'd1);
   endtask

   initial begin
      int n;
      int rate;

      // Reset state
      repeat (3) cyc(1'b0, 1'b0, 1'b0);
      chk("rst_code",   32'(coarse_code), 32'd4);
      chk("rst_sel",    32'(coarse_sel),  32'h0F);
      chk("rst_fine",   32'(fine_en),     32'd0);
      chk("rst_locked", 32'(locked),      32'd0);
      chk("rst_sat",    32'(sat_err),     32'd0);

      // Single incr, settle length, decr ignored during settle
      rst = 1'b1;
      cyc(1'b1, 1'b0, 1'b0);
      chk("idle_to_track", 32'(fine_en), 32'd1);
      repeat (3) cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b0);
      chk("incr_code", 32'(coarse_code), 32'd5);
      chk("incr_sel",  32'(coarse_sel),  32'h1F);
      chk("incr_fine", 32'(fine_en),     32'd0);
      n = 0;
      while (fine_en !== 1'b1 && n < 20) begin
         n++;
         cyc(1'b1, 1'b0, n == 2);
      end
      chk("settle_len",       32'(n),           32'd4);
      chk("settle_decr_code", 32'(coarse_code), 32'd5);

      // Saturation at the top
      restart();
      for (int k = 1; k <= 5; k++) begin
         cyc(1'b1, 1'b1, 1'b0);
         if (k < 5) begin
            chk("sat_hi_step", 32'(coarse_code), 32'(4 + k));
            wait_settle();
         end
      end
      chk("sat_hi_code", 32'(coarse_code), 32'd8);
      chk("sat_hi_sel",  32'(coarse_sel),  32'hFF);
      chk("sat_hi_flag", 32'(sat_err),     32'd1);
      chk("sat_hi_fine", 32'(fine_en),     32'd1);

      // Saturation at the bottom
      restart();
      chk("sat_cleared", 32'(sat_err), 32'd0);
      for (int k = 1; k <= 5; k++) begin
         cyc(1'b1, 1'b0, 1'b1);
         if (k < 5) begin
            chk("sat_lo_step", 32'(coarse_code), 32'(4 - k));
            wait_settle();
         end
      end
      chk("sat_lo_code", 32'(coarse_code), 32'd0);
      chk("sat_lo_sel",  32'(coarse_sel),  32'h00);
      chk("sat_lo_flag", 32'(sat_err),     32'd1);
      chk("sat_lo_fine", 32'(fine_en),     32'd1);

      // Lock after LOCK_CYC quiet cycles, loss on a step, reacquire
      restart();
      repeat (LC - 1) cyc(1'b1, 1'b0, 1'b0);
      chk("lock_early", 32'(locked), 32'd0);
      cyc(1'b1, 1'b0, 1'b0);
      chk("lock_at_64", 32'(locked), 32'd1);
      cyc(1'b1, 1'b0, 1'b1);
      chk("lock_lost",      32'(locked),      32'd0);
      chk("lock_decr_code", 32'(coarse_code), 32'd3);
      wait_settle();
      repeat (LC - 1) cyc(1'b1, 1'b0, 1'b0);
      chk("relock_early", 32'(locked), 32'd0);
      cyc(1'b1, 1'b0, 1'b0);
      chk("relock", 32'(locked), 32'd1);

      // Both carries together: ignored, but restart the quiet run
      cyc(1'b1, 1'b1, 1'b1);
      chk("both_code",   32'(coarse_code), 32'd3);
      chk("both_sat",    32'(sat_err),     32'd0);
      chk("both_locked", 32'(locked),      32'd0);
      repeat (LC - 1) cyc(1'b1, 1'b0, 1'b0);
      chk("both_lock_early", 32'(locked), 32'd0);
      cyc(1'b1, 1'b0, 1'b0);
      chk("both_relock", 32'(locked), 32'd1);

      // Disable with a carry present: carry ignored, code held
      cyc(1'b0, 1'b1, 1'b0);
      chk("dis_code", 32'(coarse_code), 32'd3);
      chk("dis_fine", 32'(fine_en),     32'd0);
      chk("dis_lock", 32'(locked),      32'd0);
      cyc(1'b1, 1'b0, 1'b0);

      // Asynchronous reset in the second settle cycle after a step to 6
      restart();
      cyc(1'b1, 1'b1, 1'b0);
      wait_settle();
      cyc(1'b1, 1'b1, 1'b0);
      chk("pre_rst_code", 32'(coarse_code), 32'd6);
      cyc(1'b1, 1'b0, 1'b0);
      rst = 1'b0;
      #1;
      chk("arst_code", 32'(coarse_code), 32'd4);
      chk("arst_sel",  32'(coarse_sel),  32'h0F);
      chk("arst_fine", 32'(fine_en),     32'd0);
      cyc(1'b1, 1'b0, 1'b0);
      rst = 1'b1;
      chk("rel_fine_idle", 32'(fine_en), 32'd0);
      cyc(1'b1, 1'b0, 1'b0);
      chk("rel_fine_track", 32'(fine_en), 32'd1);

      // Randomized traffic; carry density alternates so lock is reachable
      for (int c = 0; c < 4000; c++) begin
         rate = ((c / 300) % 2) ? 30 : 2;
         rst  = ($urandom % 700 == 0) ? 1'b0 : 1'b1;
         cyc(($urandom % 40) != 0,
             ($urandom % 100) < rate,
             ($urandom % 100) < rate);
      end
      rst = 1'b1;
      cyc(1'b1, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/coarse_ctrl.md
Name: coarse_ctrl

Overview:
- Coarse-stage controller at the far end of the fine shift register's carry interface in the delay-line tuning loop.
- Consumes the one-cycle carry_out_incr / carry_out_decr pulses from the fine stage and keeps a saturating coarse code, driven as a thermometer select.
- Gates the fine stage through fine_en, holding it off while the coarse delay settles after each step.
- Reports lock and saturation status.

Parameters:
- COARSE_NUM, 8: number of coarse delay cells, which is also the thermometer width.
- INIT_CODE, 4: coarse code loaded at reset, range 0..COARSE_NUM.
- SETTLE_CYC, 4: cycles fine_en is held low after an accepted coarse step, minimum 1.
- LOCK_CYC, 64: consecutive carry-free TRACK cycles needed to assert locked.
- CW, $clog2(COARSE_NUM+1): derived width of coarse_code; not overridden.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  loop enable; low forces IDLE.
- carry_in_incr  in  1  one-cycle pulse from the fine stage: fine code wrapped upward.
- carry_in_decr  in  1  one-cycle pulse from the fine stage: fine code wrapped downward.
- fine_en  out  1  registered enable to the fine stage.
- coarse_code  out  CW  binary coarse setting, range 0..COARSE_NUM.
- coarse_sel  out  COARSE_NUM  registered thermometer: bit i = (i < coarse_code).
- locked  out  1  registered lock indicator.
- sat_err  out  1  sticky flag: a carry arrived while the code was at its limit.

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE, coarse_code = INIT_CODE, coarse_sel = thermometer(INIT_CODE).
  - fine_en = 0, locked = 0, sat_err = 0, settle and quiet counters = 0.
- States: IDLE, TRACK, SETTLE. All outputs are registered.
- IDLE:
  - fine_en = 0; carries are ignored.
  - enable = 1 → TRACK on the next edge; fine_en goes 1 on that same edge.
- TRACK (fine_en = 1):
  - incr = 1, decr = 0, code < COARSE_NUM: code +1, coarse_sel updates on the same edge, → SETTLE, fine_en goes 0 on that edge, locked cleared, quiet counter cleared.
  - decr = 1, incr = 0, code > 0: code −1, otherwise identical to the incr case.
  - incr at code = COARSE_NUM, or decr at code = 0: code held, sat_err set to 1 (sticky until reset), quiet counter cleared, locked cleared, stay in TRACK.
  - incr and decr both 1 in the same cycle: illegal and ignored; no code change, sat_err unchanged, quiet counter cleared.
  - No carry: quiet counter increments, saturating at LOCK_CYC.
  - locked goes 1 on the edge where the quiet counter reaches LOCK_CYC, and stays 1 while TRACK is carry-free.
- SETTLE (fine_en = 0):
  - The settle counter is loaded with SETTLE_CYC−1 on entry and decrements each cycle.
  - When it is 0 → TRACK, and fine_en returns to 1.
  - fine_en is therefore low for exactly SETTLE_CYC cycles.
  - Carries arriving in SETTLE are ignored.
- enable = 0 in any state:
  - → IDLE on the next edge; fine_en = 0, locked = 0, quiet counter cleared.
  - coarse_code and sat_err are held.
  - A carry present in the same cycle as enable = 0 is ignored.
- Latency: a carry in cycle N appears on coarse_code and coarse_sel at edge N+1; fine_en is low in cycles N+1 .. N+SETTLE_CYC.
- Reset asserted mid-SETTLE or mid-TRACK returns immediately to the reset values; no partial step is retained.

Test Plan:
- Reset with defaults → coarse_code = 4, coarse_sel = 8'b0000_1111, fine_en = 0, locked = 0, sat_err = 0.
- enable = 1, single incr pulse after 3 cycles → coarse_code = 5, coarse_sel = 8'b0001_1111 at the next edge; fine_en low for exactly 4 cycles, then high; a decr pulse issued during SETTLE leaves the code at 5.
- Five incr pulses, each issued after settle completes, starting from 4 → code reaches 8 on the 4th; the 5th sets sat_err = 1 with code held at 8 and fine_en staying 1; the same check at the low end with decr from 0.
- enable = 1 with no carries for 64 TRACK cycles → locked = 1 at the 64th edge; one decr → locked = 0 and code 3; locked returns 64 carry-free TRACK cycles after settle ends.
- incr and decr asserted together in TRACK → no code change, sat_err stays 0, quiet counter restarts, so locked is delayed by 64 cycles.
- rst pulled low in the 2nd SETTLE cycle after a step to 6 → asynchronous return to code 4 and fine_en 0; with enable still 1 after rst releases → IDLE → TRACK, fine_en 1 one cycle later.
